// File: rtl/sa_tile_scheduler.sv
// sa_tile_scheduler: sequences tiled matmul on the systolic array.
// Walks output tiles (RT outer, CT inner) and, per tile, every K tile:
// load request, matrix-manager start, feed/drain PE shifting, then write-back.
// Optional performance counters are enabled by defining SA_SCHED_PERF_EN.
module sa_tile_scheduler #(
  parameter int M_DIM     = 16,
  parameter int NUM_RT    = 2,
  parameter int NUM_CT    = 2,
  parameter int NUM_KT    = 2,
  parameter int DRAIN_CYC = 2 * M_DIM - 2
) (
  input  logic       I_CLK,
  input  logic       I_SYNC_RST,
  input  logic       I_START,
  input  logic       I_STALL,
  output logic       O_BUSY,
  output logic       O_DONE,
  output logic       O_LOAD_VALID,
  input  logic       I_LOAD_READY,
  output logic [7:0] O_RT,
  output logic [7:0] O_CT,
  output logic [7:0] O_KT,
  output logic       O_MGR_START,
  input  logic       I_MGR_OVER,
  output logic       O_PE_SHIFT,
  output logic       O_ACC_CLR,
  output logic       O_RES_VALID,
  input  logic       I_RES_READY
`ifdef SA_SCHED_PERF_EN
  ,
  output logic [31:0] O_PERF_BUSY_CYC,
  output logic [31:0] O_PERF_STALL_CYC
`endif
);

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [7:0] RT_LAST = 8'(NUM_RT - 1);
  localparam logic [7:0] CT_LAST = 8'(NUM_CT - 1);
  localparam logic [7:0] KT_LAST = 8'(NUM_KT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_WB,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [7:0] rt_q, rt_d;
  logic [7:0] ct_q, ct_d;
  logic [7:0] kt_q, kt_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic load_valid_q, load_valid_d;
  logic res_valid_q, res_valid_d;
  logic mgr_start_q, mgr_start_d;
  logic acc_clr_q, acc_clr_d;
  logic pe_shift;

  // Shift enable must react to the stall input in the same cycle, so it is the one unregistered output;
  // the first FEED cycle (marked by mgr_start_q) never shifts.
  always_comb begin
    pe_shift = !I_STALL && (((state_q == S_FEED) && !mgr_start_q) || (state_q == S_DRAIN));
  end

  // Next-state, index and drain-counter logic, plus the registered-output values derived from the next state.
  always_comb begin
    state_d = state_q;
    rt_d    = rt_q;
    ct_d    = ct_q;
    kt_d    = kt_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          state_d = S_LOAD;
          rt_d    = '0;
          ct_d    = '0;
          kt_d    = '0;
        end
      end
      S_LOAD: begin
        if (I_LOAD_READY) begin
          state_d = S_FEED;
        end
      end
      S_FEED: begin
        if (pe_shift && I_MGR_OVER) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        if (pe_shift) begin
          if (drain_q == DRAIN_LAST) begin
            drain_d = '0;
            if (kt_q != KT_LAST) begin
              kt_d    = kt_q + 8'd1;
              state_d = S_LOAD;
            end else begin
              state_d = S_WB;
            end
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      end
      S_WB: begin
        if (I_RES_READY) begin
          kt_d = '0;
          if (ct_q != CT_LAST) begin
            ct_d    = ct_q + 8'd1;
            state_d = S_LOAD;
          end else if (rt_q != RT_LAST) begin
            ct_d    = '0;
            rt_d    = rt_q + 8'd1;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    load_valid_d = (state_d == S_LOAD);
    res_valid_d  = (state_d == S_WB);
    mgr_start_d  = (state_q == S_LOAD) && (state_d == S_FEED);
    acc_clr_d    = mgr_start_d && (kt_d == 8'd0);
  end

  // Single state register for the FSM, its counters and its registered outputs; reset returns everything to idle zeros.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      state_q      <= S_IDLE;
      rt_q         <= '0;
      ct_q         <= '0;
      kt_q         <= '0;
      drain_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_valid_q <= 1'b0;
      res_valid_q  <= 1'b0;
      mgr_start_q  <= 1'b0;
      acc_clr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rt_q         <= rt_d;
      ct_q         <= ct_d;
      kt_q         <= kt_d;
      drain_q      <= drain_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_valid_q <= load_valid_d;
      res_valid_q  <= res_valid_d;
      mgr_start_q  <= mgr_start_d;
      acc_clr_q    <= acc_clr_d;
    end
  end

  assign O_BUSY       = busy_q;
  assign O_DONE       = done_q;
  assign O_LOAD_VALID = load_valid_q;
  assign O_RES_VALID  = res_valid_q;
  assign O_MGR_START  = mgr_start_q;
  assign O_ACC_CLR    = acc_clr_q;
  assign O_PE_SHIFT   = pe_shift;
  assign O_RT         = rt_q;
  assign O_CT         = ct_q;
  assign O_KT         = kt_q;

`ifdef SA_SCHED_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating busy/stall cycle counters, restarted whenever a new job is accepted.
  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if ((state_q == S_IDLE) && I_START) begin
      perf_busy_d  = '0;
      perf_stall_d = '0;
    end else begin
      if (busy_q && (perf_busy_q != '1)) begin
        perf_busy_d = perf_busy_q + 32'd1;
      end
      if (((state_q == S_FEED) || (state_q == S_DRAIN)) && I_STALL && (perf_stall_q != '1)) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end
    end
  end

  // Counter registers, zeroed by reset.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign O_PERF_BUSY_CYC  = perf_busy_q;
  assign O_PERF_STALL_CYC = perf_stall_q;
`else
  // Without the performance option the scheduler carries no counter state.
`endif

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// tb_sa_tile_scheduler: directed bench for sa_tile_scheduler.
// Instance A is a single-tile job (M_DIM=4, DRAIN_CYC=6); instance B walks a 2x2x3 tile space.
// Each instance is fed by a small behavioural matrix-manager model.
module tb_sa_tile_scheduler;

  localparam int M    = 4;
  localparam int DRN  = 6;
  localparam int B_RT = 2;
  localparam int B_CT = 2;
  localparam int B_KT = 3;
  localparam int DONE_BASE = M + DRN + 5;

  logic clk;

  logic a_rst, a_start, a_stall, a_load_ready, a_res_ready, a_mgr_over;
  logic a_busy, a_done, a_load_valid, a_mgr_start, a_pe_shift, a_acc_clr, a_res_valid;
  logic [7:0] a_rt, a_ct, a_kt;

  logic b_rst, b_start, b_stall, b_load_ready, b_res_ready, b_mgr_over;
  logic b_busy, b_done, b_load_valid, b_mgr_start, b_pe_shift, b_acc_clr, b_res_valid;
  logic [7:0] b_rt, b_ct, b_kt;

`ifdef SA_SCHED_PERF_EN
  logic [31:0] a_perf_busy, a_perf_stall, b_perf_busy, b_perf_stall;
`endif

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic start;
    logic stall;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[17];

  sa_tile_scheduler #(
    .M_DIM(M), .NUM_RT(1), .NUM_CT(1), .NUM_KT(1), .DRAIN_CYC(DRN)
  ) dut_a (
    .I_CLK(clk), .I_SYNC_RST(a_rst), .I_START(a_start), .I_STALL(a_stall),
    .O_BUSY(a_busy), .O_DONE(a_done), .O_LOAD_VALID(a_load_valid), .I_LOAD_READY(a_load_ready),
    .O_RT(a_rt), .O_CT(a_ct), .O_KT(a_kt), .O_MGR_START(a_mgr_start), .I_MGR_OVER(a_mgr_over),
    .O_PE_SHIFT(a_pe_shift), .O_ACC_CLR(a_acc_clr), .O_RES_VALID(a_res_valid), .I_RES_READY(a_res_ready)
`ifdef SA_SCHED_PERF_EN
    , .O_PERF_BUSY_CYC(a_perf_busy), .O_PERF_STALL_CYC(a_perf_stall)
`endif
  );

  sa_tile_scheduler #(
    .M_DIM(M), .NUM_RT(B_RT), .NUM_CT(B_CT), .NUM_KT(B_KT), .DRAIN_CYC(DRN)
  ) dut_b (
    .I_CLK(clk), .I_SYNC_RST(b_rst), .I_START(b_start), .I_STALL(b_stall),
    .O_BUSY(b_busy), .O_DONE(b_done), .O_LOAD_VALID(b_load_valid), .I_LOAD_READY(b_load_ready),
    .O_RT(b_rt), .O_CT(b_ct), .O_KT(b_kt), .O_MGR_START(b_mgr_start), .I_MGR_OVER(b_mgr_over),
    .O_PE_SHIFT(b_pe_shift), .O_ACC_CLR(b_acc_clr), .O_RES_VALID(b_res_valid), .I_RES_READY(b_res_ready)
`ifdef SA_SCHED_PERF_EN
    , .O_PERF_BUSY_CYC(b_perf_busy), .O_PERF_STALL_CYC(b_perf_stall)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Matrix-manager models: select runs 0..M on shifts after a start; OVER flags select==M.
  logic       a_act, b_act;
  logic [7:0] a_sel, b_sel;
  assign a_mgr_over = a_act && (a_sel == 8'(M));
  assign b_mgr_over = b_act && (b_sel == 8'(M));

  always @(posedge clk) begin
    if (a_rst) begin
      a_act <= 1'b0;
      a_sel <= '0;
    end else if (a_mgr_start) begin
      a_act <= 1'b1;
      a_sel <= '0;
    end else if (a_act && a_pe_shift) begin
      if (a_sel == 8'(M)) a_act <= 1'b0;
      else a_sel <= a_sel + 8'd1;
    end
  end

  always @(posedge clk) begin
    if (b_rst) begin
      b_act <= 1'b0;
      b_sel <= '0;
    end else if (b_mgr_start) begin
      b_act <= 1'b1;
      b_sel <= '0;
    end else if (b_act && b_pe_shift) begin
      if (b_sel == 8'(M)) b_act <= 1'b0;
      else b_sel <= b_sel + 8'd1;
    end
  end

  // Safety net in case a bounded loop is somehow bypassed.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    a_start = v.start;
    a_stall = v.stall;
  endtask

  // One single-tile job on A with optional stall windows and ready delays (absolute cycle ranges).
  task automatic runJobA(input int s0, input int n0, input int s1, input int n1,
                         input int lr0, input int lrn, input int rr0, input int rrn,
                         output int done_cyc, output int shifts, output int stall_shifts, output int idx_bad);
    done_cyc = -1;
    shifts = 0;
    stall_shifts = 0;
    idx_bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      a_start      = (c == 0);
      a_stall      = (c >= s0 && c < s0 + n0) || (c >= s1 && c < s1 + n1);
      a_load_ready = !(c >= lr0 && c < lr0 + lrn);
      a_res_ready  = !(c >= rr0 && c < rr0 + rrn);
      @(negedge clk);
      if (a_pe_shift) shifts++;
      if (a_pe_shift && a_stall) stall_shifts++;
      if ((a_load_valid || a_res_valid) && (a_rt != 8'd0 || a_ct != 8'd0 || a_kt != 8'd0)) idx_bad++;
      if (a_done && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c > done_cyc && !a_busy) break;
    end
    a_start = 1'b0;
    a_stall = 1'b0;
    a_load_ready = 1'b1;
    a_res_ready = 1'b1;
  endtask

  // One multi-tile job on B; optionally pulses reset at cycle reset_at and snapshots around it.
  task automatic runJobB(input int reset_at, output int n_loads, output int n_order_bad,
                         output int n_clr, output int n_clr_bad, output int n_res, output int n_done,
                         output logic [8:0] pre_snap, output logic [30:0] post_snap);
    int e;
    n_loads = 0;
    n_order_bad = 0;
    n_clr = 0;
    n_clr_bad = 0;
    n_res = 0;
    n_done = 0;
    pre_snap = '0;
    post_snap = '1;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      b_start = (c == 0);
      b_rst   = (c == reset_at);
      @(negedge clk);
      if (b_load_valid && b_load_ready) begin
        e = n_loads;
        if (b_rt != 8'(e / (B_CT * B_KT)) || b_ct != 8'((e / B_KT) % B_CT) || b_kt != 8'(e % B_KT))
          n_order_bad++;
        n_loads++;
      end
      if (b_acc_clr) begin
        n_clr++;
        if (b_kt != 8'd0) n_clr_bad++;
      end
      if (b_res_valid && b_res_ready) n_res++;
      if (b_done) n_done++;
      if (c == reset_at) pre_snap = {b_pe_shift, b_kt};
      if (reset_at >= 0 && c == reset_at + 1)
        post_snap = {b_busy, b_done, b_load_valid, b_mgr_start, b_pe_shift, b_acc_clr, b_res_valid,
                     b_rt, b_ct, b_kt};
      if (n_done > 0 && !b_busy) break;
      if (reset_at >= 0 && c == reset_at + 6) break;
    end
    b_start = 1'b0;
    b_rst = 1'b0;
  endtask

  initial begin
    int dc, sh, ssh, ib;
    int nl, nob, nc, ncb, nr, nd;
    logic [8:0] pre;
    logic [30:0] post;

    // Single-tile golden trace: {busy, load_valid, mgr_start, acc_clr, pe_shift, res_valid, done}.
    tbl[0] = '{1'b1, 1'b0, 7'b0000000};
    tbl[1] = '{1'b0, 1'b0, 7'b1100000};
    tbl[2] = '{1'b0, 1'b0, 7'b1011000};
    for (int i = 3; i <= 13; i++) tbl[i] = '{1'b0, 1'b0, 7'b1000100};
    tbl[14] = '{1'b0, 1'b0, 7'b1000010};
    tbl[15] = '{1'b0, 1'b0, 7'b1000001};
    tbl[16] = '{1'b0, 1'b0, 7'b0000000};

    a_rst = 1'b1; a_start = 1'b0; a_stall = 1'b0; a_load_ready = 1'b1; a_res_ready = 1'b1;
    b_rst = 1'b1; b_start = 1'b0; b_stall = 1'b0; b_load_ready = 1'b1; b_res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_state_a",
                {a_busy, a_done, a_load_valid, a_mgr_start, a_pe_shift, a_acc_clr, a_res_valid, a_rt, a_ct, a_kt},
                '0);

    $display("[TB] single-tile trace");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkOutput($sformatf("single_c%0d", i),
                  {a_busy, a_load_valid, a_mgr_start, a_acc_clr, a_pe_shift, a_res_valid, a_done},
                  tbl[i].exp);
    end
    a_start = 1'b0;

    $display("[TB] stall 5 in FEED, 3 in DRAIN");
    runJobA(4, 5, 14, 3, 0, 0, 0, 0, dc, sh, ssh, ib);
    checkOutput("stall_done_cycle", dc, DONE_BASE + 8);
    checkOutput("stall_total_shifts", sh, M + 1 + DRN);
    checkOutput("stall_no_shift_when_stalled", ssh, 0);

    $display("[TB] load/result backpressure");
    runJobA(0, 0, 0, 0, 1, 4, 18, 7, dc, sh, ssh, ib);
    checkOutput("bp_done_cycle", dc, DONE_BASE + 11);
    checkOutput("bp_total_shifts", sh, M + 1 + DRN);
    checkOutput("bp_index_stable", ib, 0);

`ifdef SA_SCHED_PERF_EN
    $display("[TB] perf counters, 2 stall cycles");
    runJobA(4, 2, 0, 0, 0, 0, 0, 0, dc, sh, ssh, ib);
    checkOutput("perf_done_cycle", dc, DONE_BASE + 2);
    checkOutput("perf_busy_cyc", a_perf_busy, 17);
    checkOutput("perf_stall_cyc", a_perf_stall, 2);
`endif

    $display("[TB] tile order 2x2x3");
    runJobB(-1, nl, nob, nc, ncb, nr, nd, pre, post);
    checkOutput("order_load_count", nl, B_RT * B_CT * B_KT);
    checkOutput("order_sequence", nob, 0);
    checkOutput("order_acc_clr_count", nc, B_RT * B_CT);
    checkOutput("order_acc_clr_on_kt0", ncb, 0);
    checkOutput("order_res_handshakes", nr, B_RT * B_CT);
    checkOutput("order_done_pulses", nd, 1);

    $display("[TB] reset mid-DRAIN of K tile 1");
    runJobB(23, nl, nob, nc, ncb, nr, nd, pre, post);
    checkOutput("rst_pre_drain_kt1", pre, {1'b1, 8'd1});
    checkOutput("rst_outputs_zero", post, '0);
    checkOutput("rst_no_done", nd, 0);
    checkOutput("rst_order_before", nob, 0);

    $display("[TB] rerun after reset");
    runJobB(-1, nl, nob, nc, ncb, nr, nd, pre, post);
    checkOutput("rerun_load_count", nl, B_RT * B_CT * B_KT);
    checkOutput("rerun_sequence", nob, 0);
    checkOutput("rerun_done_pulses", nd, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
